// File: rtl/game_state_ctrl.sv
// Game flow controller: MENU -> PLAYING -> CONTINUE/FINAL screens, with lives/level/win
// registers for the HUD. One-hot state register bits drive the screen-select flags directly.
module game_state_ctrl #(
  parameter int LIVES_INIT      = 3,
  parameter int NUM_LEVELS      = 4,
  parameter int CONTINUE_FRAMES = 120,
  parameter int FINAL_FRAMES    = 180,
  localparam int LW = $clog2(LIVES_INIT + 1),
  localparam int VW = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_btn_i,
  input  logic          frame_tick_i,
  input  logic          player_hit_i,
  input  logic          level_clear_i,
  output logic          is_menu_o,
  output logic          is_playing_o,
  output logic          is_continue_o,
  output logic          is_final_o,
  output logic          round_start_o,
  output logic [LW-1:0] lives_o,
  output logic [VW-1:0] level_o,
  output logic          win_o
);

  localparam int MAXF = (CONTINUE_FRAMES > FINAL_FRAMES) ? CONTINUE_FRAMES : FINAL_FRAMES;
  localparam int CW   = $clog2(MAXF + 1);

  // One-hot encoding so each screen flag is a plain register bit.
  typedef enum logic [3:0] {
    S_MENU  = 4'b0001,
    S_PLAY  = 4'b0010,
    S_CONT  = 4'b0100,
    S_FINAL = 4'b1000
  } state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] lives_q, lives_d;
  logic [VW-1:0] level_q, level_d;
  logic          win_q, win_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          btn_q;
  logic          round_start_q, round_start_d;
  logic          start_edge;
  logic [CW-1:0] cnt_inc;

  assign start_edge = start_btn_i & ~btn_q;
  assign cnt_inc    = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

  // btn_q resets high so a button already held at reset does not start a game.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_MENU;
      lives_q       <= '0;
      level_q       <= '0;
      win_q         <= 1'b0;
      cnt_q         <= '0;
      btn_q         <= 1'b1;
      round_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      lives_q       <= lives_d;
      level_q       <= level_d;
      win_q         <= win_d;
      cnt_q         <= cnt_d;
      btn_q         <= start_btn_i;
      round_start_q <= round_start_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    lives_d       = lives_q;
    level_d       = level_q;
    win_d         = win_q;
    cnt_d         = cnt_q;
    round_start_d = 1'b0;
    case (state_q)
      S_MENU: begin
        if (start_edge) begin
          state_d       = S_PLAY;
          lives_d       = LW'(LIVES_INIT);
          level_d       = '0;
          win_d         = 1'b0;
          round_start_d = 1'b1;
        end
      end
      S_PLAY: begin
        if (player_hit_i) begin
          cnt_d = '0;
          if (lives_q <= LW'(1)) begin
            state_d = S_FINAL;
            lives_d = '0;
            win_d   = 1'b0;
          end else begin
            state_d = S_CONT;
            lives_d = lives_q - LW'(1);
          end
        end else if (level_clear_i) begin
          cnt_d = '0;
          if (level_q >= VW'(NUM_LEVELS - 1)) begin
            state_d = S_FINAL;
            win_d   = 1'b1;
          end else begin
            state_d = S_CONT;
            level_d = level_q + VW'(1);
          end
        end
      end
      S_CONT: begin
        if (frame_tick_i) cnt_d = cnt_inc;
        if (start_edge || (frame_tick_i && cnt_inc == CW'(CONTINUE_FRAMES))) begin
          state_d       = S_PLAY;
          cnt_d         = '0;
          round_start_d = 1'b1;
        end
      end
      S_FINAL: begin
        if (frame_tick_i) cnt_d = cnt_inc;
        if (start_edge || (frame_tick_i && cnt_inc == CW'(FINAL_FRAMES))) begin
          state_d = S_MENU;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_MENU;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    is_menu_o     = state_q[0];
    is_playing_o  = state_q[1];
    is_continue_o = state_q[2];
    is_final_o    = state_q[3];
    round_start_o = round_start_q;
    lives_o       = lives_q;
    level_o       = level_q;
    win_o         = win_q;
  end

endmodule
